shift_pipe: RTL and testbench

4-stage elastic pipelined 16-bit barrel shifter for the ALU shift path. Stage k conditionally shifts or rotates by 2^k (1, 2, 4, 8); the last stage is the shift-by-8 logical-right/left/rotate stage.
- Valid/ready handshake on both sides, so the shift unit can be stalled by the writeback/ALU-result consumer without losing operands.
- Throughput: one operation per cycle.

---
 rtl/shift_pkg.sv | 20 ++
 rtl/shift_pipe_if.sv | 24 ++
 rtl/shift_stage.sv | 36 +++
 rtl/shift_pipe.sv | 67 ++++++
 tb/tb_shift_pipe.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared constants and payload type for the elastic barrel-shifter pipeline.
package shift_pkg;

    localparam int unsigned SHIFT_W = 16;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned STAGES  = 4;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    // One in-flight operation as carried between pipeline stages
    typedef struct packed {
        logic [1:0]         op;
        logic [CNT_W-1:0]   cnt;
        logic [SHIFT_W-1:0] data;
    } shift_req_t;

endpackage

// File: rtl/shift_pipe_if.sv
// Valid/ready operand and result channels of the shift pipeline.
interface shift_pipe_if;
    import shift_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [SHIFT_W-1:0] in_data;
    logic [CNT_W-1:0]   in_cnt;
    logic [1:0]         in_op;
    logic               out_valid;
    logic               out_ready;
    logic [SHIFT_W-1:0] out_data;

    modport master (
        output in_valid, in_data, in_cnt, in_op, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_cnt, in_op, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/shift_stage.sv
// Combinational stage: shift or rotate by a fixed power-of-two amount when enabled.
module shift_stage
    import shift_pkg::*;
#(
    parameter int unsigned AMT = 1
) (
    input  logic [SHIFT_W-1:0] i_in,
    input  logic [1:0]         i_op,
    input  logic               i_en,
    output logic [SHIFT_W-1:0] o_out_c
);

    logic [SHIFT_W-1:0] w_sll;
    logic [SHIFT_W-1:0] w_srl;
    logic [SHIFT_W-1:0] w_rol;
    logic [SHIFT_W-1:0] w_ror;
    logic [SHIFT_W-1:0] w_sel;

    assign w_sll = i_in << AMT;
    assign w_srl = i_in >> AMT;
    assign w_rol = w_sll | (i_in >> (SHIFT_W - AMT));
    assign w_ror = w_srl | (i_in << (SHIFT_W - AMT));

    always_comb begin
        w_sel = i_in;
        case (i_op)
            OP_ROL:  w_sel = w_rol;
            OP_SLL:  w_sel = w_sll;
            OP_ROR:  w_sel = w_ror;
            default: w_sel = w_srl;
        endcase
    end

    assign o_out_c = i_en ? w_sel : i_in;

endmodule

// File: rtl/shift_pipe.sv
// Four-stage elastic barrel shifter; stage k handles count bit k (shift by 2^k).
module shift_pipe
    import shift_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    shift_pipe_if.slave  bus
);

    shift_req_t         r_stg [STAGES];
    logic [STAGES-1:0]  r_v;

    shift_req_t         w_in  [STAGES];
    logic [SHIFT_W-1:0] w_shf [STAGES];
    logic [STAGES-1:0]  w_vin;
    logic [STAGES-1:0]  w_adv;

    // Per-stage datapath and backward-rippling advance chain
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_in[k]  = '{op: bus.in_op, cnt: bus.in_cnt, data: bus.in_data};
            assign w_vin[k] = bus.in_valid && w_adv[0];
        end else begin : g_body
            assign w_in[k]  = r_stg[k-1];
            assign w_vin[k] = r_v[k-1];
        end

        if (k == STAGES - 1) begin : g_tail
            assign w_adv[k] = !r_v[k] || bus.out_ready;
        end else begin : g_mid
            assign w_adv[k] = !r_v[k] || w_adv[k+1];
        end

        shift_stage #(
            .AMT (1 << k)
        ) u_stage (
            .i_in    (w_in[k].data),
            .i_op    (w_in[k].op),
            .i_en    (w_in[k].cnt[k]),
            .o_out_c (w_shf[k])
        );
    end

    // Pipeline registers: load on advance, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                r_stg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(STAGES); i++) begin
                if (w_adv[i]) begin
                    r_v[i]        <= w_vin[i];
                    r_stg[i].op   <= w_in[i].op;
                    r_stg[i].cnt  <= w_in[i].cnt;
                    r_stg[i].data <= w_shf[i];
                end
            end
        end
    end

    assign bus.in_ready  = w_adv[0];
    assign bus.out_valid = r_v[STAGES-1];
    assign bus.out_data  = r_stg[STAGES-1].data;

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe: driver queues expected results, monitor pops and compares.
module tb_shift_pipe;
    import shift_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_pipe_if bus();

    shift_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] exp;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   ncyc  = 0;
    bit   chk_lat = 1'b0;

    // Reference: whole-word arithmetic on a 32-bit copy, truncated to 16 bits
    function automatic logic [15:0] ref_model(logic [1:0] op, logic [15:0] d, logic [3:0] c);
        int unsigned x;
        int unsigned s;
        int unsigned r;
        x = 32'(d);
        s = 32'(c);
        case (op)
            OP_ROL:  r = (x << s) | (x >> (16 - s));
            OP_SLL:  r = x << s;
            OP_ROR:  r = (x >> s) | (x << (16 - s));
            default: r = x >> s;
        endcase
        return 16'(r);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) ncyc <= ncyc + 1;

    // Monitor: every output transfer must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got %h expected none (t=%0t)", bus.out_data, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out_data", 32'(bus.out_data), 32'(e.exp));
                if (chk_lat) check("latency", 32'(ncyc - e.acc), 32'd4);
            end
        end
    end

    // Present one op, wait for acceptance, queue the expected result
    task automatic send(logic [1:0] op, logic [15:0] d, logic [3:0] c, logic [15:0] exp, bit chk_rdy);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = d;
        bus.in_cnt   = c;
        @(negedge clk);
        if (chk_rdy) check("in_ready_free", 32'(bus.in_ready), 32'd1);
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
        end else begin
            q.push_back('{exp, ncyc});
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic sendr(logic [1:0] op, logic [15:0] d, logic [3:0] c, bit chk_rdy);
        send(op, d, c, ref_model(op, d, c), chk_rdy);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        check("drain_pending", 32'(q.size()), 32'd0);
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stop;
        logic [15:0] d5;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_cnt    = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk);
        #1;

        // Latency and directed corner values
        chk_lat = 1'b1;
        send(OP_SRL, 16'hF000, 4'd12, 16'h000F, 1'b1);
        drain();
        send(OP_ROL, 16'h8001, 4'd1,  16'h0003, 1'b1);
        send(OP_ROR, 16'h0001, 4'd1,  16'h8000, 1'b1);
        send(OP_SLL, 16'h0001, 4'd15, 16'h8000, 1'b1);
        send(OP_SRL, 16'hABCD, 4'd8,  16'h00AB, 1'b1);
        send(OP_ROL, 16'h1234, 4'd0,  16'h1234, 1'b1);
        send(OP_SLL, 16'h1234, 4'd0,  16'h1234, 1'b1);
        send(OP_ROR, 16'h1234, 4'd0,  16'h1234, 1'b1);
        send(OP_SRL, 16'h1234, 4'd0,  16'h1234, 1'b1);
        send(OP_ROL, 16'hC3A5, 4'd15, 16'hE1D2, 1'b1);
        drain();

        // Back-to-back stream
        for (int i = 0; i < 8; i++) begin
            sendr(2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom_range(0, 15)), 1'b1);
        end
        drain();
        chk_lat = 1'b0;

        // Fill with consumer stalled, then release
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sendr(2'(i), 16'h9000 + 16'(i), 4'(3 * i + 1), 1'b1);
        end
        d5 = 16'h5A3C;
        bus.in_valid = 1'b1;
        bus.in_op    = OP_ROR;
        bus.in_data  = d5;
        bus.in_cnt   = 4'd7;
        repeat (3) begin
            @(negedge clk);
            check("in_ready_full",  32'(bus.in_ready),  32'd0);
            check("out_valid_full", 32'(bus.out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("in_ready_ripple", 32'(bus.in_ready), 32'd1);
        q.push_back('{ref_model(OP_ROR, d5, 4'd7), ncyc});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain();

        // Random traffic with random backpressure
        stop = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    sendr(2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom_range(0, 15)), 1'b0);
                end
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();

        // Asynchronous reset with ops in flight
        bus.out_ready = 1'b0;
        sendr(OP_ROL, 16'hA5A5, 4'd3, 1'b1);
        sendr(OP_SLL, 16'h0F0F, 4'd2, 1'b1);
        sendr(OP_SRL, 16'hFFFF, 4'd5, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_out_data",  32'(bus.out_data),  32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(OP_SLL, 16'h00FF, 4'd4, 16'h0FF0, 1'b1);
        drain();
        repeat (10) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
